ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single RAM port.
// Optional ARB_TIMEOUT_EN adds a 4-bit stall watchdog that forces IDLE and raises a sticky err.
module ram_arbiter (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [1:0]  ren,
   input  logic [1:0]  wen,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] store0,
   input  logic [31:0] store1,
   output logic [1:0]  rwait,
   output logic [31:0] load,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   output logic        ramREN,
   output logic        ramWEN,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
   localparam logic [1:0] ACCESS = 2'd2;

   state_t     state, next;
   logic       lg;
   logic [1:0] act, gnt;
   logic       gi, granted, access, abort, timeout;

   assign act     = ren | wen;
   assign gnt     = {state == GNT1, state == GNT0};
   assign granted = |gnt;
   assign gi      = gnt[1];
   // a beat completes only if the owner still holds its request
   assign access  = granted && (ramstate == ACCESS) && act[gi];
   assign abort   = granted && !act[gi];

`ifdef ARB_TIMEOUT_EN
   logic [3:0] cnt;

   assign timeout = granted && !access && !abort && (cnt == 4'd14);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         if (timeout) err <= 1'b1;
         if (granted && !access && !abort && !timeout) cnt <= cnt + 4'd1;
         else                                         cnt <= '0;
      end
   end
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   always_comb begin
      next = state;
      case (state)
         IDLE: begin
            if (act == 2'b11)  next = lg ? GNT0 : GNT1;
            else if (act[0])   next = GNT0;
            else if (act[1])   next = GNT1;
         end
         default: begin
            if (access) begin
               if (act[~gi]) next = gi ? GNT0 : GNT1;
            end else if (abort || timeout) begin
               next = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         lg    <= 1'b1;
      end else begin
         state <= next;
         if (access || timeout) lg <= gi;
      end
   end

   always_comb begin
      ramaddr  = '0;
      ramstore = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      if (granted) begin
         ramaddr  = gi ? addr1 : addr0;
         ramstore = gi ? store1 : store0;
         ramWEN   = wen[gi];
         ramREN   = ren[gi] & ~wen[gi];
      end
   end

   assign rwait = act & ~(gnt & {2{ramstate == ACCESS}});
   assign load  = ramload;

endmodule
